// File: rtl/veda_pkg.sv
// veda_pkg: shared opcode and FSM state encodings for the veda register file.
`default_nettype none

package veda_pkg;

  typedef enum logic [1:0] {
    MODE_WRITE = 2'b00,
    MODE_READ  = 2'b01,
    MODE_ADD   = 2'b10,
    MODE_SWAP  = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWAP2 = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/veda_mem.sv
// veda_mem: DEPTH x DATA_W storage, one synchronous write port, two combinational reads.
`default_nettype none

module veda_mem #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && ({1'b0, waddr} < DEPTH_L)) begin
      mem[waddr] <= wdata;
    end
  end

  // Addresses beyond DEPTH read as zero instead of indexing past the array.
  assign rdata_a = ({1'b0, raddr_a} < DEPTH_L) ? mem[raddr_a] : '0;
  assign rdata_b = ({1'b0, raddr_b} < DEPTH_L) ? mem[raddr_b] : '0;

endmodule

`default_nettype wire

// File: rtl/veda_rf.sv
// veda_rf: register file executing WRITE / READ / ADD / two-cycle SWAP commands.
`default_nettype none

module veda_rf
  import veda_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              busy,
  output logic              carry,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] addr_a_q;
  logic [DATA_W-1:0] tmp;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W:0]   sum;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              accept, a_ok, b_ok, range_err, same_addr;
  mode_t             op;

  assign op        = mode_t'(mode);
  assign accept    = cmd_valid && (state == ST_IDLE);
  assign a_ok      = {1'b0, addr_a} < DEPTH_L;
  assign b_ok      = {1'b0, addr_b} < DEPTH_L;
  assign range_err = !a_ok || (((op == MODE_ADD) || (op == MODE_SWAP)) && !b_ok);
  assign same_addr = (addr_a == addr_b);
  assign sum       = {1'b0, rd_a} + {1'b0, rd_b};

  veda_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (addr_a),
    .raddr_b (addr_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // Single write port: the SWAP2 write-back takes priority, since no command is accepted then.
  always_comb begin
    we    = 1'b0;
    waddr = addr_a;
    wdata = data_in;
    if (state == ST_SWAP2) begin
      we    = 1'b1;
      waddr = addr_a_q;
      wdata = tmp;
    end else if (accept && !range_err) begin
      case (op)
        MODE_WRITE: we = 1'b1;
        MODE_ADD: begin
          we    = 1'b1;
          wdata = sum[DATA_W-1:0];
        end
        MODE_SWAP: begin
          we    = !same_addr;
          waddr = addr_b;
          wdata = rd_a;
        end
        default: we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      addr_a_q <= '0;
      tmp      <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      carry    <= 1'b0;
      err      <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (range_err) begin
              data_out <= '0;
              err      <= 1'b1;
              valid    <= 1'b1;
            end else begin
              case (op)
                MODE_WRITE: valid <= 1'b1;
                MODE_READ: begin
                  data_out <= rd_a;
                  valid    <= 1'b1;
                end
                MODE_ADD: begin
                  data_out <= sum[DATA_W-1:0];
                  carry    <= sum[DATA_W];
                  valid    <= 1'b1;
                end
                MODE_SWAP: begin
                  data_out <= rd_a;
                  if (same_addr) begin
                    valid <= 1'b1;
                  end else begin
                    tmp      <= rd_b;
                    addr_a_q <= addr_a;
                    busy     <= 1'b1;
                    state    <= ST_SWAP2;
                  end
                end
                default: valid <= 1'b0;
              endcase
            end
          end
        end
        ST_SWAP2: begin
          busy  <= 1'b0;
          valid <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/veda_rf.md
# veda_rf

Parametrised successor to the veda register-file block. It holds DEPTH words of DATA_W bits in a single-write-port, dual-read-port storage array and executes one command per accepted strobe: write, read, in-place add, or two-cycle swap. Results are registered, and a `valid` pulse marks each completion. The block sits between the datapath controller and the ALU, acting as the architectural register store.

## Interface
Parameters:
- `DATA_W`, default 32: word width in bits, ≥ 1.
- `DEPTH`, default 32: number of words, ≥ 2. It need not be a power of two.
- `ADDR_W`, default `$clog2(DEPTH)`: address width. It is derived and must not be overridden.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset; assertion takes effect immediately.
- `cmd_valid`: input, 1 bit. Command strobe. A command is accepted on a rising edge when `cmd_valid`=1 and `busy`=0.
- `mode`: input, 2 bits. Opcode: 00 WRITE, 01 READ, 10 ADD, 11 SWAP.
- `addr_a`: input, `ADDR_W` bits. Primary address, and the destination for ADD.
- `addr_b`: input, `ADDR_W` bits. Secondary address, used by ADD and SWAP.
- `data_in`: input, `DATA_W` bits. Write data for WRITE.
- `data_out`: output, `DATA_W` bits. Registered result.
- `valid`: output, 1 bit. One-cycle pulse when a command completes.
- `busy`: output, 1 bit. High while a SWAP occupies its second cycle.
- `carry`: output, 1 bit. Carry-out of the last ADD; holds its value otherwise.
- `err`: output, 1 bit. One-cycle pulse, coincident with `valid`, for a command with an address ≥ DEPTH.

## Operation
- The storage array has one write per cycle and two combinational reads (`addr_a`, `addr_b`).
- **WRITE:** `mem[addr_a] <= data_in`. `data_out` is unchanged.
- **READ:** `data_out <= mem[addr_a]`. No write occurs.
- **ADD:** computes the sum as `DATA_W`+1 bits.
  - `mem[addr_a] <= sum[DATA_W-1:0]`, and `data_out` gets the same value.
  - `carry <= sum[DATA_W]`. The result wraps modulo 2^`DATA_W`.
  - When `addr_a` = `addr_b`, the operation doubles the word.
- **SWAP:** the FSM has two states, IDLE and SWAP2.
  - IDLE, on an accepted SWAP with `addr_a` ≠ `addr_b`:
    - `tmp <= mem[addr_b]` and `mem[addr_b] <= mem[addr_a]`.
    - `data_out <= mem[addr_a]` (the old A value).
    - Latch `addr_a` into `addr_a_q`, then go to SWAP2.
  - SWAP2: `mem[addr_a_q] <= tmp`, then return to IDLE unconditionally.
  - SWAP with `addr_a` = `addr_b` completes in one cycle, performs no write, and `data_out` gets `mem[addr_a]`.
- **Out-of-range address:** any address used by the opcode that is ≥ DEPTH triggers this path.
  - No write and no state change occur.
  - `data_out <= 0`, `carry` is unchanged, and `err` pulses.
  - The FSM stays in IDLE.
- **Commands during busy:** `cmd_valid` while `busy`=1 is ignored and dropped; there is no queue. The upstream controller holds the strobe until `busy` is low.
- `data_in` is ignored for every opcode except WRITE.

## Timing
- Reset values:
  - All `mem` words = 0, `data_out` = 0, `tmp` = 0.
  - `valid` = 0, `busy` = 0, `carry` = 0, `err` = 0.
  - FSM = IDLE.
- **Latency:**
  - WRITE, READ and ADD: the command is accepted at edge N. Memory and `data_out` update at edge N, and `valid` is high during cycle N→N+1.
  - SWAP: the first write and `data_out` update at edge N, and `busy` is high during N→N+1. The second write happens at edge N+1, and `valid` is high during N+1→N+2.
  - Same-address SWAP: same timing as READ.
- **Read-after-write:** reads are combinational on the current array contents, so a command at edge N+1 sees the writes of edge N. There is no bypass inside the same edge.
- **Reset mid-SWAP:** the operation aborts, the array clears, and the FSM returns to IDLE. No `valid` is produced.
- Release of `rst` must be synchronised externally. The first command is accepted no earlier than the first edge after deassertion.
- **Throughput:** one command per cycle, except for SWAP (one per 2 cycles).

## Structure
- Package `veda_pkg` holds:
  - The mode enum (`MODE_WRITE`, `MODE_READ`, `MODE_ADD`, `MODE_SWAP`).
  - The FSM state enum (`ST_IDLE`, `ST_SWAP2`).
- Sub-module `veda_mem` is the storage array. Parameters: `DATA_W`, `DEPTH`. Ports: one write port (`we`, `waddr`, `wdata`) and two combinational read ports. It has an async active-low clear.
- `veda_rf` contains the decoder, adder, FSM and output registers, and owns the single write-port mux.

## Test plan
- **Reset then read:** `rst` low for 2 cycles, then READ of every address → `data_out` = 0 each time, `valid` pulses, `err` = 0.
- **Write then read:** WRITE 10 to addr 3, then 11 to addr 4, then READ 3 and READ 4 → `data_out` = 10 then 11, one `valid` per command.
- **ADD wrap:** preload `mem[5]` = 0xFFFFFFFF and `mem[6]` = 2, then ADD a=5 b=6 → `data_out` = 1, `carry` = 1, `mem[5]` = 1 (check by READ). A follow-up ADD a=5 b=5 → 2 with `carry` = 0.
- **SWAP:** `mem[3]` = 10 and `mem[4]` = 11, SWAP a=3 b=4, with a WRITE strobe held during `busy`.
  - `data_out` = 10, `busy` is high for 1 cycle, and `valid` comes 2 cycles after accept.
  - The dropped WRITE leaves no trace, and READs then give `mem[3]` = 11 and `mem[4]` = 10.
  - A same-address SWAP completes in 1 cycle with no change.
- **Abort and range check:** assert `rst` during SWAP2 → all outputs 0, no `valid`, array cleared. With `DEPTH`=20, WRITE to addr 25 → `err` pulses, `data_out` = 0, and a READ of addr 25 & 0x0F (=9) still gives 0.
